// File: rtl/count_mode_pkg.sv
// Shared types and step decoding for the up/down counter mode detector.
package count_mode_pkg;

  typedef enum logic [1:0] {
    MODE_UP4 = 2'd0,
    MODE_DN4 = 2'd1,
    MODE_UP3 = 2'd2,
    MODE_DN3 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    NARROW = 2'd2,
    LOCKED = 2'd3
  } state_e;

  localparam logic [3:0] MASK_ALL = 4'b1111;

  // Bit i of the result set means mode i can produce the step p -> c.
  function automatic logic [3:0] step_modes(
    input logic [1:0] p,
    input logic [1:0] c
  );
    logic [3:0] m;
    m = 4'b0000;
    case ({p, c})
      4'b00_01, 4'b01_10: m = 4'b0101;
      4'b10_11, 4'b11_00: m = 4'b0001;
      4'b10_00:           m = 4'b0100;
      4'b11_10, 4'b00_11: m = 4'b0010;
      4'b10_01, 4'b01_00: m = 4'b1010;
      4'b00_10:           m = 4'b1000;
      default:            m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_onehot(input logic [3:0] m);
    return (m != 4'b0000) && ((m & (m - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      m[3]:    idx = 2'd3;
      m[2]:    idx = 2'd2;
      m[1]:    idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/count_step_classifier.sv
// Combinational step classifier: previous/current counter value to
// legality and the set of modes consistent with the step.
module count_step_classifier
  import count_mode_pkg::*;
(
  input  logic [1:0] p,
  input  logic [1:0] c,
  output logic       legal,
  output logic [3:0] modes
);

  assign modes = step_modes(p, c);
  assign legal = (modes != 4'b0000);

endmodule

// File: rtl/count_mode_detector.sv
// Recovers the up/down counter mode from the observed {q1,q0} stream.
// Optional COUNT_MODE_DETECT_STATS_EN builds a saturating mismatch counter.
module count_mode_detector
  import count_mode_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       q1,
  input  logic       q0,
  output logic       s1,
  output logic       s0,
  output logic       locked,
  output logic       mismatch,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  state_e           state, state_n;
  logic [1:0]       prev;
  logic [3:0]       mask, mask_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0]       mode_q, mode_n;
  logic             locked_q, locked_n;
  logic             mism_q, mism_n;

  logic [1:0]       cur;
  logic             legal;
  logic [3:0]       m_step;
  logic [3:0]       cand;

  assign cur = {q1, q0};

  count_step_classifier u_cls (
    .p     (prev),
    .c     (cur),
    .legal (legal),
    .modes (m_step)
  );

  assign cand    = mask & m_step;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_1;

  always_comb begin
    state_n  = state;
    mask_n   = mask;
    cnt_n    = cnt;
    mode_n   = mode_q;
    locked_n = locked_q;
    mism_n   = 1'b0;
    if (sample_en) begin
      unique case (state)
        EMPTY: state_n = PRIMED;
        PRIMED: begin
          if (legal) begin
            mask_n  = m_step;
            cnt_n   = CNT_1;
            state_n = NARROW;
          end else begin
            mism_n = 1'b1;
          end
        end
        NARROW, LOCKED: begin
          if (!legal) begin
            mism_n   = 1'b1;
            locked_n = 1'b0;
            mask_n   = MASK_ALL;
            cnt_n    = '0;
            state_n  = PRIMED;
          end else if (cand == 4'b0000) begin
            // Mode changed: restart training from this step alone
            mask_n  = m_step;
            cnt_n   = CNT_1;
            state_n = NARROW;
            if (state == LOCKED) begin
              mism_n   = 1'b1;
              locked_n = 1'b0;
            end
          end else if (state == NARROW) begin
            mask_n = cand;
            cnt_n  = cnt_inc;
            if (is_onehot(cand) && cnt_inc >= LOCK_C) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
              mode_n   = onehot_idx(cand);
            end
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      prev     <= 2'b00;
      mask     <= MASK_ALL;
      cnt      <= '0;
      mode_q   <= 2'b00;
      locked_q <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state    <= state_n;
      mask     <= mask_n;
      cnt      <= cnt_n;
      mode_q   <= mode_n;
      locked_q <= locked_n;
      mism_q   <= mism_n;
      if (sample_en) prev <= cur;
    end
  end

  assign s1       = mode_q[1];
  assign s0       = mode_q[0];
  assign locked   = locked_q;
  assign mismatch = mism_q;

`ifdef COUNT_MODE_DETECT_STATS_EN
  logic [7:0] err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 8'h00;
    end else if (mism_n && err_q != 8'hFF) begin
      err_q <= err_q + 8'h01;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule
